// File: rtl/seg_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg_scan_driver_if
//   Bundle of the display-data load port and the multiplexed 7-segment drive
//   outputs of seg_scan_driver.
//   master : drives load/value/dp_in/blank_lz, observes an/seg/dp/frame_done
//   slave  : the driver itself
//   load       - one-cycle strobe capturing value, dp_in, blank_lz
//   value      - four hex digits, digit0 = value[3:0]
//   dp_in      - decimal point request per digit, active-high
//   blank_lz   - leading-zero blanking enable
//   an         - anode selects, active-low, an[i] = digit i
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   dp         - decimal point segment, active-low
//   frame_done - one-cycle pulse after each four-digit scan
// ----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output load, value, dp_in, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  load, value, dp_in, blank_lz,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for a four-digit common-anode 7-segment display.
//   Each digit owns a slot of REFRESH_DIV cycles; the first DEAD_CYCLES of a
//   slot are blanked to suppress ghosting. Display data is double buffered
//   and only switched at frame boundaries so a frame never tears.
//   Ports:
//     CLOCK   - system clock, rising edge
//     RESET_N - asynchronous active-low reset
//     bus     - seg_scan_driver_if slave (load port in, display drive out)
// ----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input logic              CLOCK,
    input logic              RESET_N,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned          CNT_W    = 20;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [0:0]           ST_DEAD  = 1'b0;
    localparam logic [0:0]           ST_SHOW  = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      act_value_q, act_value_d, pend_value_q, pend_value_d;
    logic [3:0]       act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic             act_blz_q, act_blz_d, pend_blz_q, pend_blz_d;
    logic             pend_q, pend_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             fd_q, fd_d;

    logic             slot_end, frame_end;
    logic [0:0]       slot_st;
    logic [3:0]       digit;
    logic [3:0]       lz_mask;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // With no dead time the comparison would be against zero, so drop it.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign slot_st = ST_SHOW;
    end else begin : g_dead
        assign slot_st = (cnt_q < CNT_W'(DEAD_CYCLES)) ? ST_DEAD : ST_SHOW;
    end

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);
    assign digit     = act_value_q[{idx_q, 2'b00} +: 4];
    // Bit i set when digit i and every digit above it are zero; digit0 never blanks.
    assign lz_mask   = {act_value_q[15:12] == 4'h0, act_value_q[15:8] == 8'h00,
                        act_value_q[15:4] == 12'h000, 1'b0};

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = slot_end ? idx_q + 2'd1 : idx_q;
    end

    // Double buffer: a load on the boundary cycle bypasses the pending set.
    always_comb begin
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blz_d    = act_blz_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blz_d   = pend_blz_q;
        pend_d       = pend_q;
        if (frame_end) begin
            if (bus.load) begin
                act_value_d = bus.value;
                act_dp_d    = bus.dp_in;
                act_blz_d   = bus.blank_lz;
            end else if (pend_q) begin
                act_value_d = pend_value_q;
                act_dp_d    = pend_dp_q;
                act_blz_d   = pend_blz_q;
            end
            pend_d = 1'b0;
        end else if (bus.load) begin
            pend_value_d = bus.value;
            pend_dp_d    = bus.dp_in;
            pend_blz_d   = bus.blank_lz;
            pend_d       = 1'b1;
        end
    end

    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (slot_st == ST_SHOW) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (act_blz_q && lz_mask[idx_q]) ? 7'h7F : hex_to_seg(digit);
            dp_d  = ~act_dp_q[idx_q];
        end
        // Delayed one extra stage so the pulse lands on the first output of the new frame.
        wrap_d = frame_end;
        fd_d   = wrap_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            act_value_q  <= 16'h0000;
            act_dp_q     <= 4'h0;
            act_blz_q    <= 1'b0;
            pend_value_q <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_blz_q   <= 1'b0;
            pend_q       <= 1'b0;
            wrap_q       <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blz_q    <= act_blz_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blz_q   <= pend_blz_d;
            pend_q       <= pend_d;
            wrap_q       <= wrap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            fd_q         <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The parameter REFRESH_DIV SHALL default to 100000 and sets the clock cycles per digit slot (legal range 2 to 2^20).
REQ-002 The parameter DEAD_CYCLES SHALL default to 1000 and sets the blanked cycles at the start of each slot (legal range 0 to REFRESH_DIV-1).
REQ-003 CLOCK  input  1  is the single system clock; all state changes on its rising edge.
REQ-004 RESET_N  input  1  is the asynchronous, active-low reset.
REQ-005 load  input  1  is a one-cycle strobe that captures value, dp_in and blank_lz.
REQ-006 value  input  16  carries four hex digits; digit0 = value[3:0] (rightmost), digit3 = value[15:12].
REQ-007 dp_in  input  4  holds the decimal point request per digit, active-high; bit i belongs to digit i.
REQ-008 blank_lz  input  1  enables leading-zero blanking when high.
REQ-009 an  output  4  drives the anode selects, active-low; an[i] selects digit i.
REQ-010 seg  output  7  drives the segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  drives the decimal point segment, active-low.
REQ-012 frame_done  output  1  is a one-cycle pulse after each complete four-digit scan.

Function
REQ-013 A slot counter SHALL count 0 to REFRESH_DIV-1 and wrap to 0; the digit index (2 bits, 0 to 3) SHALL advance on each wrap, going 3 to 0.
REQ-014 Each slot SHALL be in state DEAD while slot count < DEAD_CYCLES, and in state SHOW otherwise.
REQ-015 In DEAD: an=4'b1111, seg=7'h7F, dp=1.
REQ-016 In SHOW: exactly one an bit SHALL be low (bit = digit index); seg = hex decode of the active digit; dp = ~dp_active[index].
REQ-017 Hex decode SHALL produce 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, A -> 7'b0001000 and F -> 7'b0001110; all 16 codes are standard.
REQ-018 Leading-zero blank: when blank_lz is active, digit i (i = 3, 2, 1) SHALL show seg=7'h7F if it and every higher digit are zero. Digit0 is never blanked. dp still follows dp_active.
REQ-019 All outputs SHALL be registered, and each reflects the counter and index values from the previous cycle (one-cycle latency).
REQ-020 Double buffering: load SHALL write a pending register set and set a pending flag. The active set SHALL be updated only at the frame boundary (slot count = REFRESH_DIV-1 while index = 3), then the flag clears.
REQ-021 If several loads occur within one frame, the last one SHALL win.
REQ-022 If load coincides with the frame-boundary cycle, the newly presented data SHALL go directly into the active set, and the pending flag SHALL end cleared.
REQ-023 No tearing: the active set SHALL never change in the middle of a frame.
REQ-024 frame_done SHALL go high for exactly one cycle, with the same registered timing as an/seg, for the cycle following each frame boundary.
REQ-025 When DEAD_CYCLES=0, the DEAD state SHALL never occur and an SHALL always have one bit low after the first output cycle.

Reset
REQ-026 When RESET_N is low, the block SHALL immediately set: an=4'b1111, seg=7'h7F, dp=1, frame_done=0, slot count=0, index=0, active/pending value=0, dp=0, blank_lz=0, pending flag=0.
REQ-027 When reset is asserted in the middle of a slot or frame, any pending load SHALL be discarded.
REQ-028 After RESET_N goes high, scanning SHALL restart at digit0, slot count 0, with no partial frame_done pulse.

Verification (REFRESH_DIV=4, DEAD_CYCLES=1)
REQ-029 Reset release then idle -> edge 1: an=1111; edges 2-4: an=1110, seg=7'b1000000; edge 5: an=1111; edges 6-8: an=1101; after 16 edges, frame_done pulses once at edge 17.
REQ-030 load value=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged until the frame ends. Next frame shows digit0 F=0001110, digit1 A=0001000, digit2 2 with dp=0, digit3 1=1111001.
REQ-031 value=16'h0005, blank_lz=1 -> digits 3..1: seg=7'h7F; digit0 seg=7'b0010010. With blank_lz=0, digits 3..1 show 7'b1000000.
REQ-032 Two loads in one frame (16'h1111, then 16'h2222) -> next frame shows 2222 only. A load on the boundary cycle -> that value shows in the very next frame.
REQ-033 RESET_N pulsed low for 1 cycle mid-slot with a load pending -> outputs go blank asynchronously. After release, 0000 is displayed and the pending data never appears.
REQ-034 DEAD_CYCLES=0 -> an never equals 4'b1111 after the first output cycle; index sequence is 0, 1, 2, 3, 0 across 20 edges.
